// File: rtl/pwm_wave_pkg.sv
// Shared wave-select encodings, default sample width and, with PWM_WAVE_SINE_EN,
// the quarter-wave sine table used by the waveform shaper.
package pwm_wave_pkg;

  localparam int DEF_SAMPLE_BITS = 8;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_sel_e;

`ifdef PWM_WAVE_SINE_EN
  // round(127*sin(i*pi/126)): entry 0 is the zero crossing, entry 63 the peak
  localparam logic [6:0] SINE_QUARTER [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd13,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd52,  7'd55,  7'd58,  7'd61,  7'd64,  7'd66,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd107, 7'd108, 7'd110, 7'd112, 7'd113, 7'd114, 7'd116, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  function automatic logic [6:0] sine_quarter(input logic [5:0] idx);
    return SINE_QUARTER[idx];
  endfunction
`endif

endpackage

// File: rtl/pwm_core.sv
// Free-running PWM: counter, duty latched on the period boundary, registered compare.
// Latency: o_pwm one clock behind the counter; no backpressure, the strobe is a bare pulse.
module pwm_core #(
  parameter int PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_pwm,
  output logic                o_period_strobe
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;
  logic                strobe;

  // Gated by enable so a stop landing on the last count never emits a pulse
  assign strobe = i_enable && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d  = '0;
    duty_d = duty_q;
    pwm_d  = 1'b0;
    if (i_enable) begin
      cnt_d = cnt_q + PWM_BITS'(1);
      pwm_d = (cnt_q < duty_q);
    end
    if (strobe) begin
      duty_d = i_duty;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign o_pwm           = pwm_q;
  assign o_period_strobe = strobe;

endmodule

// File: rtl/pwm_wave_modulator.sv
// Phase word -> shaped 8-bit sample (stage 1) -> volume-scaled sample (stage 2) -> PWM pin.
// Latency: i_phase to o_sample 2 clocks; no backpressure. PWM_WAVE_SINE_EN adds the sine source.
module pwm_wave_modulator
  import pwm_wave_pkg::*;
#(
  parameter int PHASE_BITS  = 32,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int PWM_BITS    = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [PHASE_BITS-1:0]  i_phase,
  input  logic [1:0]             i_wave_sel,
  input  logic [SAMPLE_BITS-1:0] i_volume,
  input  logic                   i_enable,
  output logic [SAMPLE_BITS-1:0] o_sample,
  output logic                   o_pwm,
  output logic                   o_period_strobe
);

  logic [SAMPLE_BITS:0]     p;
  logic                     msb;
  logic [SAMPLE_BITS-1:0]   tri_w;
  logic [SAMPLE_BITS-1:0]   wave_d, wave_q;
  logic [SAMPLE_BITS:0]     vol_p1;
  logic [2*SAMPLE_BITS-1:0] product;
  logic [SAMPLE_BITS-1:0]   sample_d, sample_q;
  logic                     unused_phase;

  assign p            = i_phase[PHASE_BITS-1 -: SAMPLE_BITS+1];
  assign msb          = p[SAMPLE_BITS];
  assign tri_w        = msb ? ~p[SAMPLE_BITS-1:0] : p[SAMPLE_BITS-1:0];
  assign unused_phase = ^i_phase[PHASE_BITS-SAMPLE_BITS-2:0];

`ifdef PWM_WAVE_SINE_EN
  logic [5:0] sine_idx;
  logic [6:0] sine_mag;
  logic [7:0] sine_w;

  // Second quadrant walks the table backwards; the lower half-cycle mirrors about 127.5
  assign sine_idx = i_phase[PHASE_BITS-2] ? ~i_phase[PHASE_BITS-3 -: 6]
                                          :  i_phase[PHASE_BITS-3 -: 6];
  assign sine_mag = sine_quarter(sine_idx);
  assign sine_w   = msb ? (8'd127 - {1'b0, sine_mag}) : (8'd128 + {1'b0, sine_mag});
`endif

  always_comb begin
    wave_d = tri_w;
    case (wave_sel_e'(i_wave_sel))
      WAVE_SQUARE: wave_d = {SAMPLE_BITS{~msb}};
      WAVE_SAW:    wave_d = p[SAMPLE_BITS:1];
      WAVE_TRI:    wave_d = tri_w;
`ifdef PWM_WAVE_SINE_EN
      WAVE_SINE:   wave_d = sine_w;
`else
      WAVE_SINE:   wave_d = tri_w;
`endif
      default:     wave_d = tri_w;
    endcase
  end

  // (volume+1) makes 255 an exact unity gain after the >>SAMPLE_BITS
  assign vol_p1   = {1'b0, i_volume} + (SAMPLE_BITS+1)'(1);
  assign product  = (2*SAMPLE_BITS)'(wave_q) * (2*SAMPLE_BITS)'(vol_p1);
  assign sample_d = product[2*SAMPLE_BITS-1 -: SAMPLE_BITS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wave_q   <= '0;
      sample_q <= '0;
    end else begin
      wave_q   <= wave_d;
      sample_q <= sample_d;
    end
  end

  assign o_sample = sample_q;

  pwm_core #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_core (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_duty         (sample_q),
    .o_pwm          (o_pwm),
    .o_period_strobe(o_period_strobe)
  );

endmodule

// File: tb/tb_pwm_wave_modulator.sv
// Directed bench for pwm_wave_modulator: sample pipeline via an expected-value queue,
// then PWM duty, boundary latching, enable and asynchronous reset behaviour.
module tb_pwm_wave_modulator;
  import pwm_wave_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] phase;
  logic [1:0]  wave_sel;
  logic [7:0]  volume;
  logic        enable;
  logic [7:0]  o_sample;
  logic        o_pwm;
  logic        o_period_strobe;

  int n_assert;
  int n_fail;
  logic [7:0] exp_q[$];

  pwm_wave_modulator dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_phase        (phase),
    .i_wave_sel     (wave_sel),
    .i_volume       (volume),
    .i_enable       (enable),
    .o_sample       (o_sample),
    .o_pwm          (o_pwm),
    .o_period_strobe(o_period_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [31:0] ph, input logic [1:0] sel,
                                       input logic [7:0] v);
    int w;
    if (sel == 2'd0)      w = ph[31] ? 0 : 255;
    else if (sel == 2'd1) w = int'(ph[31:24]);
    else                  w = ph[31] ? 255 - int'(ph[30:23]) : int'(ph[30:23]);
    return 8'((w * (int'(v) + 1)) / 256);
  endfunction

  task automatic pop_chk();
    logic [7:0] e;
    e = exp_q.pop_front();
    chk("sample", 32'(o_sample), 32'(e));
  endtask

  // Each entry is due on the second falling edge after it was pushed
  task automatic send(input logic [31:0] ph, input logic [1:0] sel, input logic [7:0] exp);
    @(negedge clk);
    if (exp_q.size() == 2) pop_chk();
    phase    = ph;
    wave_sel = sel;
    exp_q.push_back(exp);
  endtask

  task automatic flush();
    @(negedge clk);
    if (exp_q.size() == 2) pop_chk();
    @(negedge clk);
    if (exp_q.size() > 0) pop_chk();
  endtask

  task automatic wait_strobe(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_period_strobe !== 1'b1 && k < 600);
    chk(tag, 32'(o_period_strobe), 32'd1);
  endtask

  // Samples the 256 cycles after a strobe; the last one must be the next strobe
  task automatic count_period(input int vol_change_at, input logic [7:0] new_vol,
                              output int hi, output int mid_strobes, output logic end_strobe);
    hi = 0;
    mid_strobes = 0;
    end_strobe = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      hi += int'(o_pwm);
      if (k < 256) mid_strobes += int'(o_period_strobe);
      else         end_strobe = o_period_strobe;
      if (k == vol_change_at) volume = new_vol;
    end
  endtask

  initial begin
    int   hi, mid, k, strobes;
    logic ends, pwm5;
    logic [31:0] rph;
    logic [1:0]  rsel;

    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    enable   = 1'b0;
    phase    = '0;
    wave_sel = WAVE_SQUARE;
    volume   = 8'd255;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sample", 32'(o_sample), 32'd0);
    chk("rst_pwm", 32'(o_pwm), 32'd0);
    chk("rst_strobe", 32'(o_period_strobe), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unity volume: shapes pass straight through
    volume = 8'd255;
    send(32'h0000_0000, WAVE_SQUARE, 8'd255);
    send(32'h8000_0000, WAVE_SQUARE, 8'd0);
    send(32'h4000_0000, WAVE_SAW,    8'd64);
    send(32'h7F80_0000, WAVE_TRI,    8'd255);
    send(32'h8000_0000, WAVE_TRI,    8'd255);
    send(32'hFF80_0000, WAVE_TRI,    8'd0);
    send(32'h0000_0000, WAVE_TRI,    8'd0);
`ifdef PWM_WAVE_SINE_EN
    send(32'h0000_0000, WAVE_SINE,   8'd128);
    send(32'h4000_0000, WAVE_SINE,   8'd255);
    send(32'hC000_0000, WAVE_SINE,   8'd0);
`else
    send(32'h7F80_0000, WAVE_SINE,   8'd255);
    send(32'h8000_0000, WAVE_SINE,   8'd255);
    send(32'hFF80_0000, WAVE_SINE,   8'd0);
    send(32'h0000_0000, WAVE_SINE,   8'd0);
`endif
    flush();

    volume = 8'd127;
    send(32'h4000_0000, WAVE_SAW,    8'd32);
    send(32'h0000_0000, WAVE_SQUARE, 8'd127);
    send(32'h7F80_0000, WAVE_TRI,    8'd127);
    flush();

    volume = 8'd0;
    send(32'h0000_0000, WAVE_SQUARE, 8'd0);
    send(32'h7F80_0000, WAVE_TRI,    8'd0);
    flush();

    volume = 8'd200;
    for (int i = 0; i < 12; i++) begin
      rph  = $urandom;
      rsel = 2'($urandom_range(0, 2));
      send(rph, rsel, model(rph, rsel, volume));
    end
    flush();

    // Full-scale duty; volume drops mid-period but only lands on the boundary
    phase    = 32'h0000_0000;
    wave_sel = WAVE_SQUARE;
    volume   = 8'd255;
    enable   = 1'b1;
    repeat (3) @(negedge clk);
    wait_strobe("strobe_first");
    count_period(100, 8'd0, hi, mid, ends);
    chk("duty255_high", 32'(hi), 32'd255);
    chk("mid_period_strobes", 32'(mid), 32'd0);
    chk("period_len", 32'(ends), 32'd1);
    count_period(0, 8'd0, hi, mid, ends);
    chk("duty0_high", 32'(hi), 32'd0);
    chk("period_len2", 32'(ends), 32'd1);

    phase    = 32'h4000_0000;
    wave_sel = WAVE_SAW;
    volume   = 8'd127;
    repeat (3) @(negedge clk);
    wait_strobe("strobe_saw");
    count_period(0, 8'd0, hi, mid, ends);
    chk("duty32_high", 32'(hi), 32'd32);

    // Stop mid-period, then restart from count 0
    phase    = 32'h0000_0000;
    wave_sel = WAVE_SQUARE;
    volume   = 8'd255;
    repeat (3) @(negedge clk);
    wait_strobe("strobe_pre_disable");
    repeat (50) @(negedge clk);
    chk("pwm_before_disable", 32'(o_pwm), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    chk("pwm_after_disable", 32'(o_pwm), 32'd0);
    hi = 0;
    strobes = 0;
    repeat (300) begin
      @(negedge clk);
      hi += int'(o_pwm);
      strobes += int'(o_period_strobe);
    end
    chk("disabled_pwm_high", 32'(hi), 32'd0);
    chk("disabled_strobes", 32'(strobes), 32'd0);
    chk("sample_while_disabled", 32'(o_sample), 32'd255);
    enable = 1'b1;
    k = 0;
    pwm5 = 1'b0;
    while (k < 600) begin
      @(negedge clk);
      k++;
      if (k == 5) pwm5 = o_pwm;
      if (o_period_strobe === 1'b1) break;
    end
    chk("reenable_strobe_delay", 32'(k), 32'd255);
    chk("duty_kept_after_reenable", 32'(pwm5), 32'd1);

    // Async reset between edges while strobe, pwm and sample are all active
    chk("pre_rst_pwm", 32'(o_pwm), 32'd1);
    chk("pre_rst_sample", 32'(o_sample), 32'd255);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_sample", 32'(o_sample), 32'd0);
    chk("async_rst_pwm", 32'(o_pwm), 32'd0);
    chk("async_rst_strobe", 32'(o_period_strobe), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
